// File: rtl/resolver_pkg.sv
// Shared types and constants for the resolver position tracker.
package resolver_pkg;
    localparam int FAULT_WIDTH = 8;
    localparam int DATA_WIDTH  = 32;
    localparam int DEST_WIDTH  = 4;
    localparam int CNT_WIDTH   = 4;

    typedef enum logic [0:0] {ANGLE = 1'b0, SPEED = 1'b1} sample_type_t;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q3 = 2'b11;

    typedef logic [FAULT_WIDTH-1:0] fault_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction
endpackage

// File: rtl/resolver_fault_filter.sv
// Per-bit fault debounce with sticky status and a one-cycle rise interrupt.
// sticky_d_o exposes the post-sample status so results can carry it without extra latency.
module resolver_fault_filter
    import resolver_pkg::*;
#(
    parameter int DEBOUNCE_N = 3
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   sample_vld_i,
    input  fault_t fault_i,
    input  logic   clear_i,
    output fault_t sticky_d_o,
    output fault_t sticky_o,
    output logic   irq_o
);
    localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(DEBOUNCE_N);

    logic [CNT_WIDTH-1:0] cnt_q [FAULT_WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [FAULT_WIDTH];
    fault_t sticky_q, sticky_d, set_v, clr_v;
    logic   irq_q, irq_d;

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 0; i < FAULT_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_vld_i) begin
                cnt_d[i] = fault_i[i] ? sat_inc(cnt_q[i]) : '0;
                set_v[i] = fault_i[i] && (cnt_d[i] >= THRESH);
            end
            // A bit whose fault is still persisting cannot be cleared.
            clr_v[i] = clear_i && (cnt_q[i] < THRESH);
        end
        sticky_d = (sticky_q & ~clr_v) | set_v;
        irq_d    = |(sticky_d & ~sticky_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FAULT_WIDTH; i++) cnt_q[i] <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < FAULT_WIDTH; i++) cnt_q[i] <= cnt_d[i];
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    assign sticky_d_o = sticky_d;
    assign sticky_o   = sticky_q;
    assign irq_o      = irq_q;
endmodule

// File: rtl/resolver_position_tracker.sv
// Unwraps resolver angle into multi-turn position, sign-extends speed, debounces faults.
// One-cycle result latency; input never stalls, results arriving against a held output are dropped and counted.
module resolver_position_tracker
    import resolver_pkg::*;
#(
    parameter int ANGLE_WIDTH = 16,
    parameter int SPEED_WIDTH = 16,
    parameter int TURN_WIDTH  = 16,
    parameter int DEBOUNCE_N  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] data_in_data_i,
    input  logic [DEST_WIDTH-1:0] data_in_dest_i,
    input  fault_t                data_in_user_i,
    input  logic                  data_in_valid_i,
    output logic                  data_in_ready_o,
    output logic [DATA_WIDTH-1:0] data_out_data_o,
    output logic [DEST_WIDTH-1:0] data_out_dest_o,
    output fault_t                data_out_user_o,
    output logic                  data_out_valid_o,
    input  logic                  data_out_ready_i,
    input  logic                  zero_position_i,
    input  logic                  clear_faults_i,
    output fault_t                fault_status_o,
    output logic                  fault_irq_o,
    output logic [15:0]           overflow_count_o
);
    logic accept, is_angle, is_speed, res_vld;
    logic [ANGLE_WIDTH-1:0] a, c, offset_q, offset_d, prev_q, prev_d;
    logic [TURN_WIDTH-1:0]  turns_q, turns_d;
    logic                   have_ref_q, have_ref_d;
    logic [DATA_WIDTH-1:0]  res_dat, out_dat_q, out_dat_d;
    logic [DEST_WIDTH-1:0]  res_dest, out_dest_q, out_dest_d;
    fault_t                 status_nxt, out_user_q, out_user_d;
    logic                   out_vld_q, out_vld_d;
    logic [15:0]            ovf_q, ovf_d;
    logic                   unused_in;

    assign data_in_ready_o = rst_n_i;
    assign accept   = data_in_valid_i && data_in_ready_o;
    assign is_angle = accept && (data_in_dest_i == DEST_WIDTH'(ANGLE));
    assign is_speed = accept && (data_in_dest_i == DEST_WIDTH'(SPEED));
    assign res_vld  = is_angle || is_speed;
    assign a        = data_in_data_i[ANGLE_WIDTH-1:0];
    assign unused_in = ^data_in_data_i;

    resolver_fault_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_fault (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .sample_vld_i (accept),
        .fault_i      (data_in_user_i),
        .clear_i      (clear_faults_i),
        .sticky_d_o   (status_nxt),
        .sticky_o     (fault_status_o),
        .irq_o        (fault_irq_o)
    );

    always_comb begin
        offset_d   = offset_q;
        turns_d    = turns_q;
        prev_d     = prev_q;
        have_ref_d = have_ref_q;
        c          = a - offset_q;
        if (is_angle) begin
            if (!have_ref_q || zero_position_i) begin
                offset_d   = a;
                c          = '0;
                turns_d    = '0;
                prev_d     = '0;
                have_ref_d = 1'b1;
            end else begin
                // Only a Q3<->Q0 crossing is treated as a wrap of the single-turn angle.
                if (prev_q[ANGLE_WIDTH-1 -: 2] == Q3 && c[ANGLE_WIDTH-1 -: 2] == Q0)
                    turns_d = turns_q + TURN_WIDTH'(1);
                else if (prev_q[ANGLE_WIDTH-1 -: 2] == Q0 && c[ANGLE_WIDTH-1 -: 2] == Q3)
                    turns_d = turns_q - TURN_WIDTH'(1);
                prev_d = c;
            end
        end else if (zero_position_i) begin
            have_ref_d = 1'b0;
        end
    end

    assign res_dat  = is_angle ? DATA_WIDTH'({turns_d, c})
                               : DATA_WIDTH'($signed(data_in_data_i[SPEED_WIDTH-1:0]));
    assign res_dest = is_speed ? DEST_WIDTH'(SPEED) : DEST_WIDTH'(ANGLE);

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_dest_d = out_dest_q;
        out_user_d = out_user_q;
        ovf_d      = ovf_q;
        if (res_vld && (!out_vld_q || data_out_ready_i)) begin
            out_vld_d  = 1'b1;
            out_dat_d  = res_dat;
            out_dest_d = res_dest;
            out_user_d = status_nxt;
        end else begin
            if (out_vld_q && data_out_ready_i) out_vld_d = 1'b0;
            if (res_vld && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            offset_q   <= '0;
            turns_q    <= '0;
            prev_q     <= '0;
            have_ref_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_dest_q <= '0;
            out_user_q <= '0;
            ovf_q      <= '0;
        end else begin
            offset_q   <= offset_d;
            turns_q    <= turns_d;
            prev_q     <= prev_d;
            have_ref_q <= have_ref_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_dest_q <= out_dest_d;
            out_user_q <= out_user_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data_out_valid_o = out_vld_q;
    assign data_out_data_o  = out_dat_q;
    assign data_out_dest_o  = out_dest_q;
    assign data_out_user_o  = out_user_q;
    assign overflow_count_o = ovf_q;
endmodule

// File: tb/tb_resolver_position_tracker.sv
// Directed bench for resolver_position_tracker: a cycle model checks every output each cycle,
// and literal expectations after each directed step pin the model.
module tb_resolver_position_tracker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din_dat = '0;
    logic [3:0]  din_dest = '0;
    logic [7:0]  din_user = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic [31:0] dout_dat;
    logic [3:0]  dout_dest;
    logic [7:0]  dout_user;
    logic        dout_vld;
    logic        dout_rdy = 1'b1;
    logic        zero = 1'b0;
    logic        clrf = 1'b0;
    logic [7:0]  status;
    logic        irq;
    logic [15:0] ovf;

    int n_checks = 0;
    int n_errors = 0;
    localparam int DEB = 3;

    resolver_position_tracker dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .data_in_data_i   (din_dat),
        .data_in_dest_i   (din_dest),
        .data_in_user_i   (din_user),
        .data_in_valid_i  (din_vld),
        .data_in_ready_o  (din_rdy),
        .data_out_data_o  (dout_dat),
        .data_out_dest_o  (dout_dest),
        .data_out_user_o  (dout_user),
        .data_out_valid_o (dout_vld),
        .data_out_ready_i (dout_rdy),
        .zero_position_i  (zero),
        .clear_faults_i   (clrf),
        .fault_status_o   (status),
        .fault_irq_o      (irq),
        .overflow_count_o (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: plain integers describing what the outputs must be.
    int          m_off = 0, m_turns = 0, m_prev = 0;
    bit          m_ref = 0;
    int          m_run [8] = '{default: 0};
    logic [7:0]  m_st = '0;
    bit          e_vld = 0, e_irq = 0;
    logic [31:0] e_dat = '0;
    int          e_dest = 0;
    logic [7:0]  e_user = '0;
    int          e_ovf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off = 0; m_turns = 0; m_prev = 0; m_ref = 0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            m_st = '0; e_vld = 0; e_irq = 0; e_dat = '0; e_dest = 0; e_user = '0; e_ovf = 0;
        end else begin
            int old_run [8];
            logic [7:0] old_st;
            logic [31:0] rdat;
            int rdest, a, c;
            bit res;
            res = 0; rdat = '0; rdest = 0;
            old_st = m_st;
            for (int i = 0; i < 8; i++) begin
                old_run[i] = m_run[i];
                if (din_vld) m_run[i] = din_user[i] ? ((m_run[i] < 15) ? m_run[i] + 1 : 15) : 0;
                if (clrf && old_run[i] < DEB) m_st[i] = 1'b0;
                if (din_vld && din_user[i] && m_run[i] >= DEB) m_st[i] = 1'b1;
            end
            e_irq = |(m_st & ~old_st);
            if (din_vld && din_dest == 0) begin
                a = int'(din_dat[15:0]);
                if (!m_ref || zero) begin
                    m_off = a; m_turns = 0; m_prev = 0; m_ref = 1; c = 0;
                end else begin
                    c = (a - m_off + 65536) % 65536;
                    if (m_prev / 16384 == 3 && c / 16384 == 0) m_turns = (m_turns + 1) % 65536;
                    else if (m_prev / 16384 == 0 && c / 16384 == 3) m_turns = (m_turns + 65535) % 65536;
                    m_prev = c;
                end
                rdat = m_turns * 65536 + c;
                rdest = 0; res = 1;
            end else if (din_vld && din_dest == 1) begin
                rdat = $signed(din_dat[15:0]);
                rdest = 1; res = 1;
            end
            if (zero && !(din_vld && din_dest == 0)) m_ref = 0;
            if (res) begin
                if (!e_vld || dout_rdy) begin
                    e_vld = 1; e_dat = rdat; e_dest = rdest; e_user = m_st;
                end else if (e_ovf < 65535) begin
                    e_ovf++;
                end
            end else if (dout_rdy) begin
                e_vld = 0;
            end
            #1;
            if (rst_n) begin
                chk("valid", dout_vld, e_vld);
                if (e_vld) begin
                    chk("data", dout_dat, e_dat);
                    chk("dest", dout_dest, e_dest);
                    chk("user", dout_user, e_user);
                end
                chk("status", status, m_st);
                chk("irq", irq, e_irq);
                chk("overflow", ovf, e_ovf);
                chk("in_ready", din_rdy, 1);
            end
        end
    end

    task automatic send(input logic [3:0] dest, input logic [31:0] dat, input logic [7:0] user,
                        input logic zp, input logic clr);
        din_dest = dest; din_dat = dat; din_user = user; din_vld = 1'b1; zero = zp; clrf = clr;
        @(posedge clk); #2;
        din_vld = 1'b0; zero = 1'b0; clrf = 1'b0; din_user = '0;
        @(negedge clk);
    endtask

    task automatic pulse(input logic zp, input logic clr);
        zero = zp; clrf = clr;
        @(posedge clk); #2;
        zero = 1'b0; clrf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", dout_vld, 0);
        chk("rst_data", dout_dat, 0);
        chk("rst_status", status, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ready", din_rdy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_up", din_rdy, 1);

        // Unwrap: first angle references, Q3->Q0 crossing increments turns.
        send(0, 32'h1000, 0, 0, 0); chk("ang_ref", dout_dat, 32'h0000_0000);
        send(0, 32'h8000, 0, 0, 0); chk("ang_q1", dout_dat, 32'h0000_7000);
        send(0, 32'hF000, 0, 0, 0); chk("ang_q3", dout_dat, 32'h0000_E000);
        send(0, 32'h0100, 0, 0, 0); chk("ang_q3b", dout_dat, 32'h0000_F100);
        send(0, 32'h1100, 0, 0, 0); chk("ang_wrap_up", dout_dat, 32'h0001_0100);

        // Offset 0, backward wrap to turns = -1 and back.
        send(0, 32'h0000, 0, 1, 0); chk("zero_ref0", dout_dat, 32'h0);
        send(0, 32'h0100, 0, 0, 0); chk("ang_100", dout_dat, 32'h0000_0100);
        send(0, 32'hFF00, 0, 0, 0); chk("ang_wrap_dn", dout_dat, 32'hFFFF_FF00);
        send(0, 32'h0100, 0, 0, 0); chk("ang_back", dout_dat, 32'h0000_0100);

        // Zero coincident with angle, then standalone zero re-references.
        send(0, 32'h1234, 0, 1, 0); chk("zero_coinc", dout_dat, 32'h0);
        send(0, 32'h1334, 0, 0, 0); chk("after_zero", dout_dat, 32'h0000_0100);
        pulse(1, 0);
        send(0, 32'h5000, 0, 0, 0); chk("zero_alone", dout_dat, 32'h0);
        send(0, 32'h5010, 0, 0, 0); chk("after_zero2", dout_dat, 32'h0000_0010);

        // Speed sign extension and ignored dest.
        send(1, 32'h0000_8001, 0, 0, 0); chk("spd_neg", dout_dat, 32'hFFFF_8001); chk("spd_dest", dout_dest, 1);
        send(1, 32'h0001_7FFF, 0, 0, 0); chk("spd_pos", dout_dat, 32'h0000_7FFF);
        send(2, 32'hABCD, 0, 0, 0); chk("dest2_drop", dout_vld, 0);

        // Debounce: two hits, a gap, then three hits latch bit 2.
        send(1, 0, 8'h04, 0, 0); send(1, 0, 8'h04, 0, 0); send(1, 0, 8'h00, 0, 0);
        send(1, 0, 8'h04, 0, 0); send(1, 0, 8'h04, 0, 0); chk("deb_not_yet", status, 0);
        send(1, 0, 8'h04, 0, 0); chk("deb_set", status, 8'h04); chk("deb_irq", irq, 1); chk("deb_user", dout_user, 8'h04);
        pulse(0, 0); chk("irq_one_shot", irq, 0);
        pulse(0, 1); chk("clr_blocked", status, 8'h04);
        send(1, 0, 8'h00, 0, 0); pulse(0, 1); chk("clr_ok", status, 8'h00);
        send(1, 0, 8'h04, 0, 0); send(1, 0, 8'h04, 0, 0);
        send(1, 0, 8'h04, 0, 1); chk("set_wins", status, 8'h04); chk("set_wins_irq", irq, 1);
        send(2, 0, 8'h01, 0, 0); send(2, 0, 8'h01, 0, 0); send(2, 0, 8'h01, 0, 0);
        chk("dest2_fault", status, 8'h05); chk("dest2_novld", dout_vld, 0);
        send(1, 0, 8'h00, 0, 0); pulse(0, 1); chk("clr_all", status, 8'h00);

        // Back-pressure: first result held, two dropped.
        dout_rdy = 1'b0;
        send(1, 32'h11, 0, 0, 0); send(1, 32'h22, 0, 0, 0); send(1, 32'h33, 0, 0, 0);
        chk("bp_held", dout_dat, 32'h11); chk("bp_ovf", ovf, 2);
        dout_rdy = 1'b1;
        pulse(0, 0); chk("bp_drain", dout_vld, 0); chk("bp_ovf_keep", ovf, 2);

        // Asynchronous reset mid-stream.
        dout_rdy = 1'b0;
        send(1, 32'h44, 8'h02, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", dout_vld, 0); chk("arst_data", dout_dat, 0);
        chk("arst_ovf", ovf, 0); chk("arst_ready", din_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1; dout_rdy = 1'b1;
        send(0, 32'h2000, 0, 0, 0); chk("post_rst_ref", dout_dat, 32'h0);
        pulse(0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
